// File: rtl/uart_tx_fsm_ser_pkg.sv
// rtl/uart_tx_fsm_ser_pkg.sv - shared state and mux_sel encodings for the UART TX control path
package uart_tx_fsm_ser_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  // Frame walk states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Codes decoded by the downstream registered TX output mux
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // IDLE and STOP both select the stop level so the line rests high
  function automatic logic [1:0] mux_code(input state_t st);
    case (st)
      ST_START:  mux_code = MUX_START;
      ST_DATA:   mux_code = MUX_DATA;
      ST_PARITY: mux_code = MUX_PAR;
      default:   mux_code = MUX_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fsm_ser_if.sv
// rtl/uart_tx_fsm_ser_if.sv - parallel word in / serializer controls out bundle
interface uart_tx_fsm_ser_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  start_bit;
  logic                  stop_bit;
  logic                  busy;

  // Upstream word source
  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  mux_sel, ser_data, par_bit, start_bit, stop_bit, busy
  );

  // Control + serializer stage
  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output mux_sel, ser_data, par_bit, start_bit, stop_bit, busy
  );
endinterface

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational parity bit for a data word (shared with RX checker)
module uart_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_par_typ,
  output logic             o_par_bit
);

  // Even parity is the XOR of all bits; odd parity inverts it
  assign o_par_bit = (^i_data) ^ i_par_typ;

endmodule

// File: rtl/uart_tx_fsm_ser.sv
// rtl/uart_tx_fsm_ser.sv - UART TX frame FSM, shift register and bit counter
module uart_tx_fsm_ser
  import uart_tx_fsm_ser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  uart_tx_fsm_ser_if.slave    if_tx
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_busy;
  logic                  w_par_bit;

  uart_parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data    (if_tx.p_data),
    .i_par_typ (if_tx.par_typ),
    .o_par_bit (w_par_bit)
  );

  // Frame walk: latch the word in IDLE, then start, data bits LSB first, optional parity, stop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_tx.data_valid) begin
            r_shreg   <= if_tx.p_data;
            r_par_en  <= if_tx.par_en;
            r_par_bit <= w_par_bit;
            r_busy    <= 1'b1;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
          if (r_cnt == LAST_BIT) begin
            r_cnt   <= '0;
            r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          r_state <= ST_STOP;
        end
        ST_STOP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_tx.mux_sel   = mux_code(r_state);
  assign if_tx.ser_data  = r_shreg[0];
  assign if_tx.par_bit   = r_par_bit;
  assign if_tx.start_bit = 1'b0;
  assign if_tx.stop_bit  = 1'b1;
  assign if_tx.busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_fsm_ser.sv
// tb/tb_uart_tx_fsm_ser.sv - self-checking bench for uart_tx_fsm_ser
module tb_uart_tx_fsm_ser;

  localparam int DW = 8;

  typedef struct packed {
    logic [1:0] mux;
    logic       ser;
    logic       chk_ser;
    logic       par;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  logic last_par;
  exp_t q[$];

  uart_tx_fsm_ser_if #(.DATA_WIDTH(DW)) u_if ();

  uart_tx_fsm_ser #(.DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .if_tx   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as the line sees it: start, data LSB first, optional parity, stop
  task automatic push_frame(input logic [DW-1:0] w, input logic pen, input logic typ);
    logic p;
    p = (($countones(w) % 2) == 1) ^ typ;
    last_par = p;
    q.push_back({2'b00, 1'b0, 1'b0, p, 1'b1});
    for (int i = 0; i < DW; i++) q.push_back({2'b10, w[i], 1'b1, p, 1'b1});
    if (pen) q.push_back({2'b11, 1'b0, 1'b0, p, 1'b1});
    q.push_back({2'b01, 1'b0, 1'b0, p, 1'b1});
  endtask

  task automatic check_entry(input exp_t e, input string tag);
    check({tag, "_mux"}, 16'(u_if.mux_sel), 16'(e.mux));
    if (e.chk_ser) check({tag, "_ser"}, 16'(u_if.ser_data), 16'(e.ser));
    check({tag, "_par"}, 16'(u_if.par_bit), 16'(e.par));
    check({tag, "_busy"}, 16'(u_if.busy), 16'(e.busy));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mux"}, 16'(u_if.mux_sel), 16'h1);
    check({tag, "_busy"}, 16'(u_if.busy), 16'h0);
    check({tag, "_par"}, 16'(u_if.par_bit), 16'(last_par));
    check({tag, "_startbit"}, 16'(u_if.start_bit), 16'h0);
    check({tag, "_stopbit"}, 16'(u_if.stop_bit), 16'h1);
  endtask

  task automatic scramble_inputs();
    u_if.p_data     = DW'($urandom);
    u_if.par_en     = 1'($urandom);
    u_if.par_typ    = 1'($urandom);
    u_if.data_valid = 1'($urandom);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after the frame
  task automatic run_frame(input logic [DW-1:0] w, input logic pen, input logic typ, input string tag);
    exp_t e;
    u_if.p_data     = w;
    u_if.par_en     = pen;
    u_if.par_typ    = typ;
    u_if.data_valid = 1'b1;
    push_frame(w, pen, typ);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      check_entry(e, tag);
      scramble_inputs();
      if (q.size() == 0) u_if.data_valid = 1'b0;
      @(negedge clk);
    end
    check_idle({tag, "_idle"});
  endtask

  initial begin
    exp_t e;
    n_vec = 0;
    n_fail = 0;
    last_par = 1'b0;
    rst_n = 1'b0;
    u_if.p_data = '0;
    u_if.data_valid = 1'b0;
    u_if.par_en = 1'b0;
    u_if.par_typ = 1'b0;

    // Reset state and idle line
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_ser", 16'(u_if.ser_data), 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("idle5");
    end

    // Directed frames
    run_frame(8'hA5, 1'b0, 1'b0, "a5_nopar");
    run_frame(8'hA5, 1'b1, 1'b0, "a5_even");
    run_frame(8'h01, 1'b1, 1'b1, "01_odd");
    run_frame(8'h03, 1'b1, 1'b1, "03_odd");
    run_frame(8'h03, 1'b0, 1'b1, "03_odd_nopar");
    run_frame(8'h00, 1'b1, 1'b0, "00_even");
    run_frame(8'hFF, 1'b1, 1'b1, "ff_odd");

    // Random frames
    for (int k = 0; k < 8; k++)
      run_frame(DW'($urandom), 1'($urandom), 1'($urandom), "rand");

    // data_valid held high, inputs changing every cycle
    for (int c = 0; c < 70; c++) begin
      if (q.size() == 0) begin
        check_idle("cont_idle");
        u_if.p_data     = DW'($urandom);
        u_if.par_en     = 1'($urandom);
        u_if.par_typ    = 1'($urandom);
        u_if.data_valid = 1'b1;
        push_frame(u_if.p_data, u_if.par_en, u_if.par_typ);
      end else begin
        e = q.pop_front();
        check_entry(e, "cont");
        u_if.p_data  = DW'($urandom);
        u_if.par_en  = 1'($urandom);
        u_if.par_typ = 1'($urandom);
      end
      @(negedge clk);
    end
    u_if.data_valid = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_entry(e, "drain");
      @(negedge clk);
    end
    check_idle("drain_idle");

    // Reset in the 4th DATA cycle aborts the frame at once
    u_if.p_data     = 8'hC3;
    u_if.par_en     = 1'b1;
    u_if.par_typ    = 1'b0;
    u_if.data_valid = 1'b1;
    push_frame(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    u_if.data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front();
      check_entry(e, "prerst");
      if (i < 4) @(negedge clk);
    end
    q.delete();
    #2;
    rst_n = 1'b0;
    last_par = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_ser", 16'(u_if.ser_data), 16'h0);
    @(negedge clk);
    check_idle("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    run_frame(8'h5A, 1'b1, 1'b1, "post_rst_frame");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
